// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/sequencing controller.
package pipeline_stall_ctrl_pkg;

    typedef logic [4:0] stall_t;

    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EXE = 3;
    localparam int unsigned STALL_MEM = 4;

    localparam stall_t STALL_NONE     = 5'b00000;
    localparam stall_t STALL_LOAD_USE = 5'b00111;
    localparam stall_t STALL_DIV      = 5'b01111;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_enum;

    function automatic logic reg_hit(input logic re, input logic [4:0] ra, input logic [4:0] wa);
        return re && (ra == wa);
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Decode/EXE hazard inputs and per-stage stall controls of the stall controller.
interface pipeline_stall_ctrl_if;
    import pipeline_stall_ctrl_pkg::*;

    logic       id_i_rfre1;
    logic [4:0] id_i_rfra1;
    logic       id_i_rfre2;
    logic [4:0] id_i_rfra2;
    logic       exe_i_dm2rf;
    logic       exe_i_rfwe;
    logic [4:0] exe_i_rfwa;
    logic       exe_i_div_req;
    stall_t     stall;
    logic       idexe_bubble;
    logic       div_init;
    logic       div_step;
    logic       div_done;

    modport master (
        output id_i_rfre1, id_i_rfra1, id_i_rfre2, id_i_rfra2,
        output exe_i_dm2rf, exe_i_rfwe, exe_i_rfwa, exe_i_div_req,
        input  stall, idexe_bubble, div_init, div_step, div_done
    );

    modport slave (
        input  id_i_rfre1, id_i_rfra1, id_i_rfre2, id_i_rfra2,
        input  exe_i_dm2rf, exe_i_rfwe, exe_i_rfwa, exe_i_div_req,
        output stall, idexe_bubble, div_init, div_step, div_done
    );

endinterface

// File: rtl/pipeline_stall_ctrl_div_seq.sv
// Sequencer for the iterative divider: init pulse, DIV_CYCLES steps, then one done cycle.
module pipeline_stall_ctrl_div_seq
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic cpu_clk,
    input  logic cpu_rst,
    input  logic div_req,
    output logic idle,
    output logic div_init,
    output logic div_step,
    output logic div_done,
    output logic busy
);

    localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_CYCLES - 1);

    div_state_enum   state_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_req) begin
                        state_q <= DIV_RUN;
                        cnt_q   <= '0;
                    end
                end
                DIV_RUN: begin
                    if (cnt_q == CntLast) begin
                        state_q <= DIV_DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // The DIV leaves EXE here, so the request is never re-sampled for it.
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

    // Outputs are forced low during reset so a mid-divide reset emits nothing.
    always_comb begin
        idle     = !cpu_rst && (state_q == DIV_IDLE);
        div_init = idle && div_req;
        div_step = !cpu_rst && (state_q == DIV_RUN);
        div_done = !cpu_rst && (state_q == DIV_DONE);
        busy     = div_init || div_step;
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: load-use bubble insertion, divider sequencing and a
// saturating stalled-cycle counter.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    pipeline_stall_ctrl_if.slave ctrl,
    output logic [CNT_W-1:0]     perf_stall_cnt
);

    logic       div_idle;
    logic       div_init;
    logic       div_step;
    logic       div_done;
    logic       div_busy;
    logic       lu_hit;
    logic       load_use;
    stall_t     stall;
    logic [CNT_W-1:0] perf_q;

    pipeline_stall_ctrl_div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .div_req  (ctrl.exe_i_div_req),
        .idle     (div_idle),
        .div_init (div_init),
        .div_step (div_step),
        .div_done (div_done),
        .busy     (div_busy)
    );

    always_comb begin
        lu_hit = ctrl.exe_i_dm2rf && ctrl.exe_i_rfwe && (ctrl.exe_i_rfwa != REG_ZERO) &&
                 (reg_hit(ctrl.id_i_rfre1, ctrl.id_i_rfra1, ctrl.exe_i_rfwa) ||
                  reg_hit(ctrl.id_i_rfre2, ctrl.id_i_rfra2, ctrl.exe_i_rfwa));
        // A divide request takes precedence over any load-use match in the same cycle.
        load_use = div_idle && !ctrl.exe_i_div_req && lu_hit;

        stall = STALL_NONE;
        if (div_busy) begin
            stall = STALL_DIV;
        end else if (load_use) begin
            stall = STALL_LOAD_USE;
        end
    end

    assign ctrl.stall        = stall;
    assign ctrl.idexe_bubble = load_use;
    assign ctrl.div_init     = div_init;
    assign ctrl.div_step     = div_step;
    assign ctrl.div_done     = div_done;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            perf_q <= '0;
        end else if (stall[STALL_PC] && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per cycle, a monitor
// pops and compares on the falling edge.
module tb_pipeline_stall_ctrl;
    import pipeline_stall_ctrl_pkg::*;

    localparam logic [4:0] S0  = 5'b00000;
    localparam logic [4:0] SLU = 5'b00111;
    localparam logic [4:0] SDV = 5'b01111;

    typedef struct {
        string       name;
        logic [8:0]  ctl;   // {stall, bubble, init, step, done}
        logic [31:0] cnt;
        logic [3:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic [31:0] cnt;
    logic [3:0]  cnt2;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          pushes = 0;
    int          pops = 0;
    int          ncyc = 0;
    bit          stim_done = 1'b0;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt2;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if bus ();
    pipeline_stall_ctrl_if bus2 ();

    pipeline_stall_ctrl #(
        .DIV_CYCLES (32),
        .CNT_W      (32)
    ) dut (
        .cpu_clk        (clk),
        .cpu_rst        (rst),
        .ctrl           (bus.slave),
        .perf_stall_cnt (cnt)
    );

    // Narrow-counter instance held in a permanent load-use condition to reach saturation.
    pipeline_stall_ctrl #(
        .DIV_CYCLES (4),
        .CNT_W      (4)
    ) dut_sat (
        .cpu_clk        (clk),
        .cpu_rst        (rst2),
        .ctrl           (bus2.slave),
        .perf_stall_cnt (cnt2)
    );

    task automatic cyc(input string name, input logic r,
                       input logic dm2rf, input logic rfwe, input logic [4:0] rfwa,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2, input logic div,
                       input logic [4:0] es, input logic eb, input logic ei,
                       input logic est, input logic ed);
        exp_t e;
        rst                = r;
        rst2               = (ncyc < 3);
        bus.exe_i_dm2rf    = dm2rf;
        bus.exe_i_rfwe     = rfwe;
        bus.exe_i_rfwa     = rfwa;
        bus.id_i_rfre1     = re1;
        bus.id_i_rfra1     = ra1;
        bus.id_i_rfre2     = re2;
        bus.id_i_rfra2     = ra2;
        bus.exe_i_div_req  = div;
        e.name = name;
        e.ctl  = {es, eb, ei, est, ed};
        e.cnt  = m_cnt;
        e.cnt2 = m_cnt2;
        sb.push_back(e);
        pushes++;
        if (r) m_cnt = '0;
        else if (es[0] && m_cnt != '1) m_cnt = m_cnt + 1;
        if (rst2) m_cnt2 = '0;
        else if (m_cnt2 != 4'hf) m_cnt2 = m_cnt2 + 1'b1;
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input string name, input logic r);
        cyc(name, r, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, S0, 0, 0, 0, 0);
    endtask

    task automatic div_full(input string name);
        cyc({name, "_init"}, 0, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0, 1, SDV, 0, 1, 0, 0);
        for (int k = 1; k <= 32; k++)
            cyc({name, "_step"}, 0, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0, 1, SDV, 0, 0, 1, 0);
        cyc({name, "_done"}, 0, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0, 1, S0, 0, 0, 0, 1);
    endtask

    // Monitor: every cycle with a pending expectation gets compared.
    initial begin
        exp_t e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                pops++;
                got = {bus.stall, bus.idexe_bubble, bus.div_init, bus.div_step, bus.div_done};
                total++;
                if (got !== e.ctl) begin
                    bad++;
                    $display("FAIL %s ctl got=%b want=%b", e.name, got, e.ctl);
                end
                total++;
                if (cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL %s perf_cnt got=%0d want=%0d", e.name, cnt, e.cnt);
                end
                total++;
                if (cnt2 !== e.cnt2) begin
                    bad++;
                    $display("FAIL %s sat_cnt got=%0d want=%0d", e.name, cnt2, e.cnt2);
                end
            end else if (stim_done) begin
                total++;
                if (pops != pushes) begin
                    bad++;
                    $display("FAIL drain popped=%0d pushed=%0d", pops, pushes);
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.exe_i_dm2rf   = 1'b1;
        bus2.exe_i_rfwe    = 1'b1;
        bus2.exe_i_rfwa    = 5'd8;
        bus2.id_i_rfre1    = 1'b1;
        bus2.id_i_rfra1    = 5'd8;
        bus2.id_i_rfre2    = 1'b0;
        bus2.id_i_rfra2    = 5'd0;
        bus2.exe_i_div_req = 1'b0;

        rst  = 1'b1;
        rst2 = 1'b1;
        bus.exe_i_dm2rf   = 0;
        bus.exe_i_rfwe    = 0;
        bus.exe_i_rfwa    = 0;
        bus.id_i_rfre1    = 0;
        bus.id_i_rfra1    = 0;
        bus.id_i_rfre2    = 0;
        bus.id_i_rfra2    = 0;
        bus.exe_i_div_req = 0;
        @(posedge clk);
        #1;
        m_cnt  = '0;
        m_cnt2 = '0;

        idle_cyc("reset", 1);
        idle_cyc("idle", 0);

        // Load-use on rs then rt; exactly one bubble each.
        cyc("lu_rs",     0, 1, 1, 5'd8, 1, 5'd8, 0, 5'd0,  0, SLU, 1, 0, 0, 0);
        cyc("lu_rs_clr", 0, 0, 0, 5'd0, 1, 5'd8, 0, 5'd0,  0, S0,  0, 0, 0, 0);
        cyc("lu_rt",     0, 1, 1, 5'd9, 0, 5'd0, 1, 5'd9,  0, SLU, 1, 0, 0, 0);
        cyc("lu_rt_clr", 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd9,  0, S0,  0, 0, 0, 0);

        // Non-hazards.
        cyc("lu_r0",     0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0,  0, S0, 0, 0, 0, 0);
        cyc("lu_nore",   0, 1, 1, 5'd8, 0, 5'd8, 0, 5'd8,  0, S0, 0, 0, 0, 0);
        cyc("lu_nowe",   0, 1, 0, 5'd8, 1, 5'd8, 0, 5'd0,  0, S0, 0, 0, 0, 0);
        cyc("lu_noload", 0, 0, 1, 5'd8, 1, 5'd8, 0, 5'd0,  0, S0, 0, 0, 0, 0);
        cyc("lu_miss",   0, 1, 1, 5'd8, 1, 5'd9, 1, 5'd10, 0, S0, 0, 0, 0, 0);

        // Single DIV: 33 stalled cycles from a cleared counter.
        idle_cyc("rst_div1", 1);
        div_full("div1");
        idle_cyc("div1_after", 0);

        // Back-to-back DIVs: 66 stalled cycles.
        idle_cyc("rst_div2", 1);
        div_full("divA");
        div_full("divB");
        idle_cyc("div2_after", 0);

        // Reset while the counter is at 10: no step, no done afterwards.
        cyc("mid_init", 0, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0, 1, SDV, 0, 1, 0, 0);
        for (int k = 0; k < 10; k++)
            cyc("mid_step", 0, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0, 1, SDV, 0, 0, 1, 0);
        cyc("mid_rst", 1, 0, 1, 5'd2, 0, 5'd0, 0, 5'd0, 1, S0, 0, 0, 0, 0);
        for (int k = 0; k < 36; k++) idle_cyc("post_rst", 0);

        cyc("lu_again", 0, 1, 1, 5'd12, 0, 5'd0, 1, 5'd12, 0, SLU, 1, 0, 0, 0);
        idle_cyc("final", 0);

        stim_done = 1'b1;
    end

endmodule
